// File: rtl/tdc_uart_tx.sv
// tdc_uart_tx: serialises a TDC stage-delay snapshot as one UART frame.
// Frame: start, 8 data bits LSB first, optional even parity, one stop.
module tdc_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int NUM_STAGES   = 5,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NUM_STAGES-1:0] stage_delays,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          par, par_n;
  logic          tx_n, busy_n, done_n;
  logic          last;
  logic [7:0]    byte_in;

  assign last    = (cnt == CNT_LAST);
  assign byte_in = 8'(stage_delays);

  // Next-state, datapath and registered-output values for the frame
  always_comb begin
    state_n = state;
    cnt_n   = last ? '0 : cnt + 1'b1;
    idx_n   = idx;
    shreg_n = shreg;
    par_n   = par;
    tx_n    = tx;
    busy_n  = busy;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        tx_n  = 1'b1;
        if (start) begin
          state_n = START;
          busy_n  = 1'b1;
          tx_n    = 1'b0;
          idx_n   = 3'd0;
          shreg_n = byte_in;
          par_n   = ^byte_in;
        end
      end
      START: begin
        if (last) begin
          state_n = DATA;
          cnt_n   = '0;
          tx_n    = shreg[0];
        end
      end
      DATA: begin
        if (last) begin
          cnt_n = '0;
          if (idx == 3'd7) begin
            idx_n = 3'd0;
            if (PARITY_EN) begin
              state_n = PARITY;
              tx_n    = par;
            end else begin
              state_n = STOP;
              tx_n    = 1'b1;
            end
          end else begin
            idx_n   = idx + 3'd1;
            shreg_n = {1'b0, shreg[7:1]};
            tx_n    = shreg[1];
          end
        end
      end
      PARITY: begin
        if (last) begin
          state_n = STOP;
          cnt_n   = '0;
          tx_n    = 1'b1;
        end
      end
      STOP: begin
        if (last) begin
          state_n = IDLE;
          cnt_n   = '0;
          tx_n    = 1'b1;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State, counters and line outputs; reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= 3'd0;
      shreg <= 8'd0;
      par   <= 1'b0;
      tx    <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shreg <= shreg_n;
      par   <= par_n;
      tx    <= tx_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

endmodule

// File: tb/tb_tdc_uart_tx.sv
// tb_tdc_uart_tx: checks a plain and a parity instance side by side
// against a frame-level reference model driven by the same stimulus.
module tb_tdc_uart_tx;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] sd;
  logic       tx0, busy0, done0;
  logic       tx1, busy1, done1;

  int nchk = 0;
  int nerr = 0;
  bit chk_on = 0;

  always #5 clk = ~clk;

  tdc_uart_tx #(.CLKS_PER_BIT(C), .NUM_STAGES(5), .PARITY_EN(1'b0)) dut0 (
    .clk(clk), .reset(rst), .start(start), .stage_delays(sd),
    .tx(tx0), .busy(busy0), .done(done0)
  );

  tdc_uart_tx #(.CLKS_PER_BIT(C), .NUM_STAGES(5), .PARITY_EN(1'b1)) dut1 (
    .clk(clk), .reset(rst), .start(start), .stage_delays(sd),
    .tx(tx1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of bits, each held C cycles
  bit         m_act[2];
  int         m_t[2];
  logic [7:0] m_b[2];
  bit         m_dn[2];

  function automatic int nbits(input int i);
    return (i == 1) ? 11 : 10;
  endfunction

  function automatic logic exp_tx(input int i);
    int slot;
    if (!m_act[i]) return 1'b1;
    slot = m_t[i] / C;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return m_b[i][slot-1];
    if (i == 1 && slot == 9) return ^m_b[i];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      m_dn[i] = 0;
      if (!rst) begin
        m_act[i] = 0;
      end else if (m_act[i]) begin
        m_t[i]++;
        if (m_t[i] == nbits(i) * C) begin
          m_act[i] = 0;
          m_dn[i]  = 1;
        end
      end else if (start) begin
        m_act[i] = 1;
        m_t[i]   = 0;
        m_b[i]   = {3'b000, sd};
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("tx0", 32'(tx0), 32'(exp_tx(0)));
      chk("busy0", 32'(busy0), 32'(m_act[0]));
      chk("done0", 32'(done0), 32'(m_dn[0]));
      chk("tx1", 32'(tx1), 32'(exp_tx(1)));
      chk("busy1", 32'(busy1), 32'(m_act[1]));
      chk("done1", 32'(done1), 32'(m_dn[1]));
    end
  end

  // Raise start for the edge that follows; returns just after that edge
  task automatic kick(input logic [4:0] d);
    sd    = d;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy0 || busy1) && n < 80) begin
      @(posedge clk);
      #1 n++;
    end
    chk(tag, 32'({busy0, busy1}), 32'd0);
  endtask

  initial begin
    int n, d0, d1, second, ndone;
    logic [7:0] rx0, rx1;
    logic       pbit;
    logic [4:0] d;

    rst   = 1'b0;
    start = 1'b1;
    sd    = 5'b10110;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) chk_on = 1;
      chk("rst_tx", 32'({tx0, tx1}), 32'h3);
      chk("rst_busy", 32'({busy0, busy1}), 32'h0);
      chk("rst_done", 32'({done0, done1}), 32'h0);
    end
    start = 1'b0;
    rst   = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("post_rst_idle", 32'({busy0, busy1}), 32'h0);

    kick(5'b10110);
    sd = 5'b11111;
    n  = 0;
    d0 = -1;
    d1 = -1;
    rx0 = 8'h00;
    rx1 = 8'h00;
    pbit = 1'b0;
    while (n < 50) begin
      @(posedge clk);
      #1 n++;
      for (int k = 0; k < 8; k++)
        if (n == (1 + k) * C + 2) begin
          rx0[k] = tx0;
          rx1[k] = tx1;
        end
      if (n == 9 * C + 2) pbit = tx1;
      if (done0 && d0 < 0) d0 = n;
      if (done1 && d1 < 0) d1 = n;
    end
    chk("byte0", 32'(rx0), 32'h16);
    chk("byte1", 32'(rx1), 32'h16);
    chk("parity", 32'(pbit), 32'h1);
    chk("done0_at", 32'(d0), 32'd40);
    chk("done1_at", 32'(d1), 32'd44);

    kick(5'b10110);
    n = 0;
    second = -1;
    while (n < 100) begin
      @(posedge clk);
      #1 n++;
      if (n == 10) start = 1'b1;
      if (n == 11) start = 1'b0;
      if (n == 38) start = 1'b1;
      if (n == 47) start = 1'b0;
      if (second < 0 && n >= 40 && tx0 == 1'b0) second = n;
    end
    chk("b2b_spacing", 32'(second), 32'd41);
    wait_idle("b2b_idle");

    kick(5'b01101);
    n = 0;
    ndone = 0;
    while (n < 70) begin
      @(posedge clk);
      #1 n++;
      if (n == 17) rst = 1'b0;
      if (n == 18) begin
        chk("abort_tx", 32'({tx0, tx1}), 32'h3);
        chk("abort_busy", 32'({busy0, busy1}), 32'h0);
        rst = 1'b1;
      end
      if (done0 || done1) ndone++;
    end
    chk("abort_nodone", 32'(ndone), 32'd0);

    for (int r = 0; r < 8; r++) begin
      d = 5'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1 kick(d);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 20)) @(posedge clk);
        #1 sd = 5'($urandom);
      end
      wait_idle("rand_idle");
      @(posedge clk);
      #1;
    end

    chk_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
